punc_mem_arbiter: RTL and testbench

- Shares PUnC's single-port 16-bit data/instruction memory between two requesters: the PUnC core (CPU port: fetch, LD/LDI/LDR, ST/STI/STR) and a debug/program-loader port (DBG).
- Sits between the PUnC control/datapath and the memory.
- Grants one access per cycle with CPU-preferred, burst-limited round-robin.
- Routes the 1-cycle-latency read data back to the requester that issued the read.

---
 rtl/punc_mem_arbiter_if.sv | 64 ++++++
 rtl/punc_mem_arbiter.sv | 137 +++++++++++++
 tb/tb_punc_mem_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/punc_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// punc_mem_arbiter_if
//   Bundles the two requester ports (PUnC core = cpu_*, debug/loader = dbg_*)
//   and the single-port memory side of the PUnC memory arbiter.
//
//   Requester signals (per port cpu_/dbg_):
//     *_req    request, held until granted
//     *_we     1 = write, 0 = read
//     *_addr   word address
//     *_wdata  write data
//     *_gnt    combinational grant
//     *_rvalid read data valid (one cycle after a granted read)
//     *_rdata  read data
//   Memory signals:
//     mem_addr, mem_w_en, mem_w_data  driven by the arbiter
//     mem_r_data                      synchronous read data from memory
//
//   Modports:
//     master : the environment (requesters and the memory itself)
//     slave  : the arbiter
// ---------------------------------------------------------------------------
interface punc_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_w_en;
  logic [DATA_W-1:0] mem_w_data;
  logic [DATA_W-1:0] mem_r_data;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_addr, mem_w_en, mem_w_data,
    output mem_r_data
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_addr, mem_w_en, mem_w_data,
    input  mem_r_data
  );
endinterface

// File: rtl/punc_mem_arbiter.sv
// ---------------------------------------------------------------------------
// punc_mem_arbiter
//   Shares PUnC's single-port 16-bit memory between the CPU and a debug /
//   program-loader port. One access is granted per cycle. When both ports
//   request, the last granted port (owner) keeps the memory until it has
//   had BURST consecutive grants, then the other port gets it. Read data
//   (1-cycle latency) is flagged back to the port that issued the read.
//
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous reset, active low (0 = in reset)
//     bus  punc_mem_arbiter_if.slave - both requester ports plus memory side
// ---------------------------------------------------------------------------
module punc_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int BURST  = 4
) (
  input  logic               clk,
  input  logic               rst,
  punc_mem_arbiter_if.slave  bus
);

  localparam int              CNT_W   = $clog2(BURST + 1);
  localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_CPU  = 2'd1,
    RD_DBG  = 2'd2
  } rd_pend_e;

  owner_e            r_owner;
  owner_e            w_owner_next;
  logic [CNT_W-1:0]  r_burst_cnt;
  logic [CNT_W-1:0]  w_burst_cnt_next;
  rd_pend_e          r_rd_pend;
  rd_pend_e          w_rd_pend_next;

  logic              w_gnt_cpu;
  logic              w_gnt_dbg;
  logic [ADDR_W-1:0] w_mem_addr;
  logic              w_mem_w_en;
  logic [DATA_W-1:0] w_mem_w_data;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner     <= OWN_CPU;
      r_burst_cnt <= '0;
      r_rd_pend   <= RD_NONE;
    end else begin
      r_owner     <= w_owner_next;
      r_burst_cnt <= w_burst_cnt_next;
      r_rd_pend   <= w_rd_pend_next;
    end
  end

  // Arbitration. Grants are gated by rst so every output is quiet while
  // reset is held, even though the grant path itself is combinational.
  always_comb begin
    w_gnt_cpu = 1'b0;
    w_gnt_dbg = 1'b0;
    if (rst) begin
      if (bus.cpu_req && bus.dbg_req) begin
        if (r_burst_cnt < BURST_C) begin
          w_gnt_cpu = (r_owner == OWN_CPU);
          w_gnt_dbg = (r_owner == OWN_DBG);
        end else begin
          // Owner has used its burst: hand over to the waiting port.
          w_gnt_cpu = (r_owner == OWN_DBG);
          w_gnt_dbg = (r_owner == OWN_CPU);
        end
      end else begin
        w_gnt_cpu = bus.cpu_req;
        w_gnt_dbg = bus.dbg_req;
      end
    end
  end

  // Memory mux: the granted port drives the memory, zeros when idle.
  always_comb begin
    w_mem_addr   = '0;
    w_mem_w_en   = 1'b0;
    w_mem_w_data = '0;
    if (w_gnt_cpu) begin
      w_mem_addr   = bus.cpu_addr;
      w_mem_w_en   = bus.cpu_we;
      w_mem_w_data = bus.cpu_wdata;
    end else if (w_gnt_dbg) begin
      w_mem_addr   = bus.dbg_addr;
      w_mem_w_en   = bus.dbg_we;
      w_mem_w_data = bus.dbg_wdata;
    end
  end

  // Next-state: owner / burst counter / pending read tag
  always_comb begin
    w_owner_next     = r_owner;
    w_burst_cnt_next = '0;       // an idle cycle restarts the burst
    w_rd_pend_next   = RD_NONE;
    if (w_gnt_cpu) begin
      if (r_owner == OWN_CPU) begin
        w_burst_cnt_next = (r_burst_cnt == BURST_C) ? BURST_C : r_burst_cnt + ONE_C;
      end else begin
        w_owner_next     = OWN_CPU;
        w_burst_cnt_next = ONE_C;
      end
      if (!bus.cpu_we) w_rd_pend_next = RD_CPU;
    end else if (w_gnt_dbg) begin
      if (r_owner == OWN_DBG) begin
        w_burst_cnt_next = (r_burst_cnt == BURST_C) ? BURST_C : r_burst_cnt + ONE_C;
      end else begin
        w_owner_next     = OWN_DBG;
        w_burst_cnt_next = ONE_C;
      end
      if (!bus.dbg_we) w_rd_pend_next = RD_DBG;
    end
  end

  assign bus.cpu_gnt    = w_gnt_cpu;
  assign bus.dbg_gnt    = w_gnt_dbg;
  assign bus.cpu_rvalid = (r_rd_pend == RD_CPU);
  assign bus.dbg_rvalid = (r_rd_pend == RD_DBG);
  assign bus.cpu_rdata  = bus.mem_r_data;
  assign bus.dbg_rdata  = bus.mem_r_data;
  assign bus.mem_addr   = w_mem_addr;
  assign bus.mem_w_en   = w_mem_w_en;
  assign bus.mem_w_data = w_mem_w_data;

endmodule

// File: tb/tb_punc_mem_arbiter.sv
module tb_punc_mem_arbiter;

  localparam int BURST = 4;

  logic clk;
  logic rst;

  punc_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) intf ();

  punc_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .BURST(BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (intf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port memory: registered read, write at the edge.
  logic [15:0] tb_mem [0:65535];
  initial begin
    for (int i = 0; i < 65536; i++) tb_mem[i] = 16'(i * 7) ^ 16'h5A5A;
    intf.mem_r_data = 16'h0;
    forever begin
      @(posedge clk);
      intf.mem_r_data <= tb_mem[intf.mem_addr];
      if (intf.mem_w_en) tb_mem[intf.mem_addr] = intf.mem_w_data;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model: who was granted last, how many grants in a row it has
  // had (unbounded), what read is outstanding, and the expected memory image.
  logic [15:0] ref_mem [0:65535];
  int          m_last;      // 1 = CPU, 2 = DBG
  int          m_streak;
  int          m_pend;      // 0 none, 1 CPU, 2 DBG
  logic [15:0] m_pend_data;
  int          m_winner;    // winner of the most recent cycle
  logic        obs_cpu_gnt, obs_dbg_gnt, obs_cpu_rvalid, obs_dbg_rvalid;
  logic [15:0] obs_cpu_rdata, obs_dbg_rdata;

  task automatic model_reset();
    m_last   = 1;
    m_streak = 0;
    m_pend   = 0;
  endtask

  task automatic drive_cycle(input logic cr, input logic cwe, input logic [15:0] ca, input logic [15:0] cwd,
                             input logic dr, input logic dwe, input logic [15:0] da, input logic [15:0] dwd);
    int          win;
    logic [15:0] e_addr, e_wd;
    logic        e_we;
    @(posedge clk);
    #1;
    intf.cpu_req = cr; intf.cpu_we = cwe; intf.cpu_addr = ca; intf.cpu_wdata = cwd;
    intf.dbg_req = dr; intf.dbg_we = dwe; intf.dbg_addr = da; intf.dbg_wdata = dwd;
    @(negedge clk);
    if (cr && dr) win = (m_streak >= BURST) ? (3 - m_last) : m_last;
    else if (cr)  win = 1;
    else if (dr)  win = 2;
    else          win = 0;
    e_addr = (win == 1) ? ca  : (win == 2) ? da  : 16'h0;
    e_we   = (win == 1) ? cwe : (win == 2) ? dwe : 1'b0;
    e_wd   = (win == 1) ? cwd : (win == 2) ? dwd : 16'h0;

    check_val("cpu_gnt",    32'(intf.cpu_gnt),    32'(win == 1));
    check_val("dbg_gnt",    32'(intf.dbg_gnt),    32'(win == 2));
    check_val("mem_addr",   32'(intf.mem_addr),   32'(e_addr));
    check_val("mem_w_en",   32'(intf.mem_w_en),   32'(e_we));
    check_val("mem_w_data", 32'(intf.mem_w_data), 32'(e_wd));
    check_val("cpu_rvalid", 32'(intf.cpu_rvalid), 32'(m_pend == 1));
    check_val("dbg_rvalid", 32'(intf.dbg_rvalid), 32'(m_pend == 2));
    if (m_pend == 1) check_val("cpu_rdata", 32'(intf.cpu_rdata), 32'(m_pend_data));
    if (m_pend == 2) check_val("dbg_rdata", 32'(intf.dbg_rdata), 32'(m_pend_data));

    $display("t=%0t cpu(req=%0b we=%0b a=%h) dbg(req=%0b we=%0b a=%h) gnt=%0b%0b rv=%0b%0b rdata=%h",
             $time, cr, cwe, ca, dr, dwe, da, intf.cpu_gnt, intf.dbg_gnt,
             intf.cpu_rvalid, intf.dbg_rvalid, intf.mem_r_data);

    obs_cpu_gnt    = intf.cpu_gnt;    obs_dbg_gnt    = intf.dbg_gnt;
    obs_cpu_rvalid = intf.cpu_rvalid; obs_dbg_rvalid = intf.dbg_rvalid;
    obs_cpu_rdata  = intf.cpu_rdata;  obs_dbg_rdata  = intf.dbg_rdata;

    // advance the model
    m_winner = win;
    if (win == 0) begin
      m_streak = 0;
      m_pend   = 0;
    end else begin
      if (win == m_last) m_streak++;
      else begin
        m_last   = win;
        m_streak = 1;
      end
      if (e_we) begin
        ref_mem[e_addr] = e_wd;
        m_pend = 0;
      end else begin
        m_pend      = win;
        m_pend_data = ref_mem[e_addr];
      end
    end
  endtask

  task automatic idle();
    drive_cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic        c_req, c_we, d_req, d_we;
  logic [15:0] c_addr, c_wd, d_addr, d_wd;

  initial begin
    for (int i = 0; i < 65536; i++) ref_mem[i] = 16'(i * 7) ^ 16'h5A5A;
    rst = 1'b0;
    intf.cpu_req = 0; intf.cpu_we = 0; intf.cpu_addr = 0; intf.cpu_wdata = 0;
    intf.dbg_req = 0; intf.dbg_we = 0; intf.dbg_addr = 0; intf.dbg_wdata = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // 1. reset asserted while a CPU read is in flight
    drive_cycle(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    rst = 1'b0;
    #1;
    check_val("rst_cpu_gnt",  32'(intf.cpu_gnt),    32'd0);
    check_val("rst_mem_addr", 32'(intf.mem_addr),   32'd0);
    check_val("rst_mem_w_en", 32'(intf.mem_w_en),   32'd0);
    check_val("rst_rvalid",   32'(intf.cpu_rvalid), 32'd0);
    @(posedge clk); #1;
    check_val("rst_rvalid_hold", 32'(intf.cpu_rvalid), 32'd0);
    intf.cpu_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    idle();
    check_val("rst_no_rvalid", 32'(obs_cpu_rvalid), 32'd0);
    drive_cycle(1'b1, 1'b0, 16'h0001, 16'h0, 1'b1, 1'b0, 16'h0002, 16'h0);
    check_val("rst_first_both_cpu", 32'(obs_cpu_gnt), 32'd1);
    idle();

    // 2. single CPU read of a word loaded through the debug port
    drive_cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h3000, 16'h1234);
    drive_cycle(1'b1, 1'b0, 16'h3000, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    check_val("p2_gnt", 32'(obs_cpu_gnt), 32'd1);
    idle();
    check_val("p2_rvalid", 32'(obs_cpu_rvalid), 32'd1);
    check_val("p2_rdata",  32'(obs_cpu_rdata),  32'h1234);
    check_val("p2_dbg_rvalid", 32'(obs_dbg_rvalid), 32'd0);

    // 3. DBG write then CPU read of the same address next cycle
    drive_cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h0040, 16'hBEEF);
    drive_cycle(1'b1, 1'b0, 16'h0040, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    idle();
    check_val("p3_rdata", 32'(obs_cpu_rdata), 32'hBEEF);

    // 4. continuous contention from an idle start with owner=CPU
    for (int i = 0; i < 16; i++) begin
      drive_cycle(1'b1, 1'b0, 16'h0005, 16'h0, 1'b1, 1'b0, 16'h0006, 16'h0);
      check_val("p4_pattern", 32'(obs_cpu_gnt), 32'(((i / BURST) % 2) == 0));
    end
    idle();

    // 5. CPU alone saturates its burst, then DBG wins the first contended cycle
    idle();
    for (int i = 0; i < 10; i++) drive_cycle(1'b1, 1'b0, 16'(i), 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive_cycle(1'b1, 1'b0, 16'h0007, 16'h0, 1'b1, 1'b0, 16'h0008, 16'h0);
    check_val("p5_dbg_wins", 32'(obs_dbg_gnt), 32'd1);

    // 6. idle gap with owner=DBG, then DBG keeps a full burst
    idle();
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, 1'b0, 16'h0009, 16'h0, 1'b1, 1'b0, 16'h000A, 16'h0);
      check_val("p6_pattern", 32'(obs_dbg_gnt), 32'(i < BURST));
    end

    // randomized traffic, requests held until granted, occasional withdrawal
    c_req = 0; d_req = 0;
    c_we = 0; d_we = 0; c_addr = 0; d_addr = 0; c_wd = 0; d_wd = 0;
    for (int n = 0; n < 400; n++) begin
      if (!c_req) begin
        if ($urandom_range(0, 99) < 70) begin
          c_req = 1; c_we = 1'($urandom_range(0, 1));
          c_addr = 16'($urandom_range(0, 15)); c_wd = 16'($urandom);
        end
      end else if ($urandom_range(0, 99) < 5) c_req = 0;
      if (!d_req) begin
        if ($urandom_range(0, 99) < 60) begin
          d_req = 1; d_we = 1'($urandom_range(0, 1));
          d_addr = 16'($urandom_range(0, 15)); d_wd = 16'($urandom);
        end
      end else if ($urandom_range(0, 99) < 5) d_req = 0;
      drive_cycle(c_req, c_we, c_addr, c_wd, d_req, d_we, d_addr, d_wd);
      if (m_winner == 1) c_req = 0;
      if (m_winner == 2) d_req = 0;
    end
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
